// File: rtl/weight_fetch_ctrl_if.sv
// rtl/weight_fetch_ctrl_if.sv - request, ROM and weight-stream signals of the weight fetch controller
interface weight_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   num_words;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;
    logic                  w_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, num_words, rom_data, w_ready,
        output rom_en, rom_addr, w_data, w_valid, w_last, busy, done
    );

    modport slave (
        output start, base_addr, num_words, rom_data, w_ready,
        input  rom_en, rom_addr, w_data, w_valid, w_last, busy, done
    );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - streams a contiguous run of ROM words to the PE array through a 4-deep buffer
module weight_fetch_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    weight_fetch_ctrl_if.master    wf
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [CW-1:0]         total_q, total_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         popped_q, popped_d;

    // pend_q marks the cycle in which rom_data carries the word of the previous read
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            count_q;

    logic push, pop, w_valid, w_last, room;

    assign push    = pend_q;
    assign w_valid = (count_q != 3'd0);
    assign pop     = w_valid && wf.w_ready;
    assign w_last  = w_valid && (popped_q == total_q - CW'(1));
    // Reads in flight are counted against the buffer so a returning word always has a slot
    assign room    = (4'(count_q) + 4'(rom_en_q) + 4'(pend_q)) < 4'd4;

    assign wf.rom_en   = rom_en_q;
    assign wf.rom_addr = rom_addr_q;
    assign wf.w_data   = fifo_mem[rd_ptr_q];
    assign wf.w_valid  = w_valid;
    assign wf.w_last   = w_last;
    assign wf.busy     = (state_q == FETCH) || (state_q == DRAIN);
    assign wf.done     = (state_q == DONE);

    // Return buffer: captures ROM data one cycle after each read, drains on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else begin
            pend_q <= rom_en_q;
            if (push) begin
                fifo_mem[wr_ptr_q] <= wf.rom_data;
                wr_ptr_q           <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(push) - 3'(pop);
        end
    end

    // Control state and read-issue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            next_addr_q <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
        end else begin
            state_q     <= state_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            next_addr_q <= next_addr_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
        end
    end

    // Next-state, read issue and word accounting
    always_comb begin
        state_d     = state_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        next_addr_d = next_addr_q;
        total_d     = total_q;
        issued_d    = issued_q;
        popped_d    = pop ? popped_q + CW'(1) : popped_q;
        case (state_q)
            IDLE: begin
                if (wf.start) begin
                    total_d  = wf.num_words;
                    popped_d = '0;
                    if (wf.num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        // Buffer is empty in IDLE, so the first read goes out immediately
                        state_d     = FETCH;
                        rom_en_d    = 1'b1;
                        rom_addr_d  = wf.base_addr;
                        next_addr_d = wf.base_addr + ADDR_WIDTH'(1);
                        issued_d    = CW'(1);
                    end
                end
            end
            FETCH: begin
                if (issued_q == total_q) begin
                    state_d = DRAIN;
                end else if (room) begin
                    rom_en_d    = 1'b1;
                    rom_addr_d  = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    issued_d    = issued_q + CW'(1);
                end
            end
            DRAIN: begin
                if (pop && w_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
